sync_fifo: RTL and testbench

Single-clock first-in/first-out buffer with registered read data and a one-cycle data-valid strobe. It decouples a producer and a consumer that share one clock. Its full and empty flags provide back-pressure, and illegal operations (writes when full, reads when empty) are ignored.

---
 rtl/sync_fifo.sv | 47 ++++
 tb/tb_sync_fifo.sv | 103 ++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and a one-cycle valid strobe.
// Flags decode from the occupancy count so they only change after a clock edge.
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  full,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic                  wr_acc, rd_acc;
   assign empty  = count == '0;
   assign full   = count == CW'(DEPTH);
   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;
   // Storage is deliberately left unreset; reset only makes it unreachable.
   always_ff @(posedge clk)
      if (wr_acc) mem[wr_ptr] <= data_in;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         data_out <= '0;
         valid    <= 1'b0;
      end else begin
         valid <= rd_acc;
         if (wr_acc) wr_ptr <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
         if (rd_acc) begin
            rd_ptr   <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            data_out <= mem[rd_ptr];
         end
         count <= wr_acc & ~rd_acc ? count + 1'b1 :
                  rd_acc & ~wr_acc ? count - 1'b1 : count;
      end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard bench for sync_fifo; a queue of written words predicts read data and flags.
module tb_sync_fifo;
   localparam int DW = 8;
   localparam int DEPTH = 16;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0, rd_en = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          full, empty, valid;
   logic [DW-1:0] data_out;
   logic [DW-1:0] mq[$];
   logic [DW-1:0] last = '0;
   int            errors = 0, checks = 0, nr = 0, nw = 0;

   sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
      .full(full), .empty(empty), .data_out(data_out), .valid(valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drives one cycle, predicts acceptance from the model occupancy, then checks all outputs.
   task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
      logic wa, ra;
      @(negedge clk);
      wr_en = w; rd_en = r; data_in = d;
      wa = w && mq.size() != DEPTH;
      ra = r && mq.size() != 0;
      @(posedge clk);
      #1;
      if (ra) begin last = mq.pop_front(); nr++; end
      if (wa) begin mq.push_back(d); nw++; end
      check("valid", valid, ra);
      check("data", data_out, last);
      check("full", full, mq.size() == DEPTH);
      check("empty", empty, mq.size() == 0);
   endtask

   initial begin
      #12 rst_n = 1'b1;
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_valid", valid, 0);
      // reset mid-stream with 5 words stored and valid high
      for (int i = 0; i < 6; i++) cycle(1, 0, DW'(8'h30 + i));
      cycle(0, 1, 0);
      check("pre_rst_valid", valid, 1);
      #2 rst_n = 1'b0;
      #1;
      mq.delete(); last = '0;
      check("arst_empty", empty, 1);
      check("arst_full", full, 0);
      check("arst_valid", valid, 0);
      check("arst_data", data_out, 0);
      @(negedge clk) rst_n = 1'b1;
      cycle(0, 1, 0);
      // fill to full, attempt a dropped 17th write, drain in order
      for (int i = 0; i < 16; i++) cycle(1, 0, DW'(8'h10 + i));
      cycle(1, 0, 8'hAA);
      for (int i = 0; i < 16; i++) begin
         cycle(0, 1, 0);
         check("fill_order", data_out, 8'h10 + i);
      end
      check("no_aa_left", mq.size(), 0);
      // reads while empty are ignored
      for (int i = 0; i < 4; i++) cycle(0, 1, 0);
      cycle(1, 0, 8'h5C);
      cycle(0, 1, 0);
      check("5c_read", data_out, 8'h5C);
      cycle(0, 0, 0);
      // wrap-around with random traffic and full back-pressure
      nw = 0; nr = 0;
      for (int c = 0; c < 400 && nr < 28; c++)
         cycle(nw < 28 && !full && $urandom_range(0, 3) != 0,
               nw >= 3 && $urandom_range(0, 2) != 0, DW'($urandom));
      check("wrap_done", nr, 28);
      // simultaneous read+write at count 8
      for (int i = 0; i < 8; i++) cycle(1, 0, DW'(8'h40 + i));
      for (int i = 0; i < 10; i++) begin
         cycle(1, 1, DW'(8'h80 + i));
         check("rw8_count", mq.size(), 8);
      end
      for (int i = 0; i < 8; i++) cycle(0, 1, 0);
      // simultaneous read+write when full: write dropped
      for (int i = 0; i < 16; i++) cycle(1, 0, DW'(8'hC0 + i));
      cycle(1, 1, 8'hEE);
      check("rwfull_full", full, 0);
      check("rwfull_count", mq.size(), 15);
      for (int i = 0; i < 15; i++) cycle(0, 1, 0);
      check("rwfull_last", data_out, 8'hCF);
      cycle(0, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
